icache_dm_refill: RTL

- Direct-mapped instruction cache in the IF stage.
- Answers the fetch PC each cycle with an instruction plus valid; valid low is the I-cache miss the hazard controller turns into IF stall/flush.
- On a miss, runs a line refill from the memory side.
- Hazard control itself is out of scope: this block is the producer of the fetch-side cache_output signals, not their consumer.

---
 rtl/mips_core_pkg.sv | 44 ++++
 rtl/icache_refill_fsm.sv | 92 +++++++++
 rtl/icache_dm_refill.sv | 127 ++++++++++++
 3 files changed

// File: rtl/mips_core_pkg.sv
// ----------------------------------------------------------------------------
// mips_core_pkg
// Shared types and helpers for the direct-mapped instruction cache.
//   icache_state_t  : refill controller state (IDLE, REQ, REFILL)
//   DEF_*           : default geometry (32 lines x 4 words, 32-bit addresses)
//   *_width()       : address-field widths derived from a geometry
//   line_base_mask(): mask that clears word-offset and byte bits of an address
// ----------------------------------------------------------------------------
package mips_core_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REQ    = 2'd1,
      REFILL = 2'd2
   } icache_state_t;

   localparam int DEF_ADDR_WIDTH      = 32;
   localparam int DEF_INDEX_WIDTH     = 5;
   localparam int DEF_LINE_WORDS_LOG2 = 2;

   // Byte address = {tag, index, word offset, 2'b byte}
   function automatic int offset_lsb();
      return 2;
   endfunction

   function automatic int index_lsb(input int line_words_log2);
      return line_words_log2 + 2;
   endfunction

   function automatic int tag_lsb(input int index_width, input int line_words_log2);
      return index_width + line_words_log2 + 2;
   endfunction

   function automatic int tag_width(input int addr_width, input int index_width,
                                    input int line_words_log2);
      return addr_width - index_width - line_words_log2 - 2;
   endfunction

   // 64 bits wide so any ADDR_WIDTH up to 64 can slice what it needs.
   function automatic logic [63:0] line_base_mask(input int line_words_log2);
      return ~((64'd1 << (line_words_log2 + 2)) - 64'd1);
   endfunction

endpackage

// File: rtl/icache_refill_fsm.sv
// ----------------------------------------------------------------------------
// icache_refill_fsm
// Miss/refill controller for icache_dm_refill. Owns the state, the latched
// line base of the miss, the refill beat counter and the memory handshake.
// Ports:
//   clk, rst_n        : clock, async active-low reset
//   req_valid, hit    : fetch request present / array lookup result
//   req_addr          : fetch byte address
//   mem_req_ready     : memory accepts the line request
//   mem_rsp_valid     : one refill beat present
//   state             : current state (array read gating in the top)
//   miss_addr         : line base of the line being refilled
//   mem_req_valid     : registered line read request
//   line_inval        : clear valid of the requested index (miss starts)
//   word_we, word_sel : write refill beat into data[miss index][word_sel]
//   line_done         : last beat; write tag and set valid for miss index
//   start_miss        : IDLE->REQ transition this cycle
// ----------------------------------------------------------------------------
module icache_refill_fsm
   import mips_core_pkg::*;
#(
   parameter int ADDR_WIDTH      = DEF_ADDR_WIDTH,
   parameter int LINE_WORDS_LOG2 = DEF_LINE_WORDS_LOG2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       req_valid,
   input  logic                       hit,
   input  logic [ADDR_WIDTH-1:0]      req_addr,
   input  logic                       mem_req_ready,
   input  logic                       mem_rsp_valid,
   output icache_state_t              state,
   output logic [ADDR_WIDTH-1:0]      miss_addr,
   output logic                       mem_req_valid,
   output logic                       line_inval,
   output logic                       word_we,
   output logic [LINE_WORDS_LOG2-1:0] word_sel,
   output logic                       line_done,
   output logic                       start_miss
);

   localparam logic [63:0]           MASK64    = line_base_mask(LINE_WORDS_LOG2);
   localparam logic [ADDR_WIDTH-1:0] BASE_MASK = MASK64[ADDR_WIDTH-1:0];

   logic [LINE_WORDS_LOG2-1:0] beat_cnt;

   // Array strobes must line up with the beat on the bus, so they are decoded
   // from the registered state rather than registered themselves.
   assign start_miss = (state == IDLE) & req_valid & ~hit;
   assign line_inval = start_miss;
   assign word_we    = (state == REFILL) & mem_rsp_valid;
   assign word_sel   = beat_cnt;
   assign line_done  = word_we & (beat_cnt == '1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         miss_addr     <= '0;
         beat_cnt      <= '0;
         mem_req_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start_miss) begin
                  miss_addr     <= req_addr & BASE_MASK;
                  mem_req_valid <= 1'b1;
                  state         <= REQ;
               end
            end
            REQ: begin
               if (mem_req_ready) begin
                  mem_req_valid <= 1'b0;
                  beat_cnt      <= '0;
                  state         <= REFILL;
               end
            end
            REFILL: begin
               if (mem_rsp_valid) begin
                  // Counter wraps to 0 on the last beat by width.
                  beat_cnt <= beat_cnt + 1'b1;
                  if (beat_cnt == '1) state <= IDLE;
               end
            end
            default: begin
               state         <= IDLE;
               mem_req_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/icache_dm_refill.sv
// ----------------------------------------------------------------------------
// icache_dm_refill
// Direct-mapped instruction cache for the IF stage. Combinational lookup of
// req_addr (0-cycle hit latency); on a miss a full line is refilled from
// memory in ascending word order, after which the current req_addr is looked
// up again. out_valid low is the miss indication for the fetch stage.
// Ports:
//   clk, rst_n                   : clock, async active-low reset
//   req_addr, req_valid          : fetch byte address / request present
//   out_valid, out_data          : instruction at req_addr this cycle
//   mem_req_valid, mem_req_addr  : line read request (held until ready)
//   mem_req_ready                : memory accepts the request
//   mem_rsp_valid, mem_rsp_data  : refill beats
//   perf_hits, perf_misses       : saturating event counters, only when
//                                  ICACHE_PERF_CNT_EN is defined
// ----------------------------------------------------------------------------
module icache_dm_refill
   import mips_core_pkg::*;
#(
   parameter int INDEX_WIDTH     = DEF_INDEX_WIDTH,
   parameter int LINE_WORDS_LOG2 = DEF_LINE_WORDS_LOG2,
   parameter int ADDR_WIDTH      = DEF_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic                  req_valid,
   output logic                  out_valid,
   output logic [31:0]           out_data,
   output logic                  mem_req_valid,
   output logic [ADDR_WIDTH-1:0] mem_req_addr,
   input  logic                  mem_req_ready,
   input  logic                  mem_rsp_valid,
   input  logic [31:0]           mem_rsp_data
`ifdef ICACHE_PERF_CNT_EN
   ,
   output logic [31:0]           perf_hits,
   output logic [31:0]           perf_misses
`endif
);

   localparam int LINES      = 1 << INDEX_WIDTH;
   localparam int LINE_WORDS = 1 << LINE_WORDS_LOG2;
   localparam int OFF_LO     = offset_lsb();
   localparam int IDX_LO     = index_lsb(LINE_WORDS_LOG2);
   localparam int TAG_LO     = tag_lsb(INDEX_WIDTH, LINE_WORDS_LOG2);
   localparam int TAG_W      = tag_width(ADDR_WIDTH, INDEX_WIDTH, LINE_WORDS_LOG2);

   logic [LINES-1:0]                             valid_q;
   logic [LINES-1:0][TAG_W-1:0]                  tag_q;
   logic [LINES-1:0][LINE_WORDS-1:0][31:0]       data_q;

   logic [INDEX_WIDTH-1:0]     req_idx, miss_idx;
   logic [LINE_WORDS_LOG2-1:0] req_off, word_sel;
   logic [TAG_W-1:0]           req_tag, miss_tag;
   logic [ADDR_WIDTH-1:0]      miss_addr;
   icache_state_t              state;
   logic                       hit, line_inval, word_we, line_done, start_miss;

   assign req_off  = req_addr[OFF_LO +: LINE_WORDS_LOG2];
   assign req_idx  = req_addr[IDX_LO +: INDEX_WIDTH];
   assign req_tag  = req_addr[TAG_LO +: TAG_W];
   assign miss_idx = miss_addr[IDX_LO +: INDEX_WIDTH];
   assign miss_tag = miss_addr[TAG_LO +: TAG_W];

   // Byte bits and the zeroed low bits of the line base carry no information.
   logic unused_bits;
   assign unused_bits = ^{req_addr[OFF_LO-1:0], miss_addr[IDX_LO-1:0]};

   assign hit       = req_valid & valid_q[req_idx] & (tag_q[req_idx] == req_tag);
   // Busy refilling blocks all hits, including ones to unrelated lines.
   assign out_valid = hit & (state == IDLE);
   assign out_data  = out_valid ? data_q[req_idx][req_off] : 32'd0;

   assign mem_req_addr = miss_addr;

   icache_refill_fsm #(
      .ADDR_WIDTH      (ADDR_WIDTH),
      .LINE_WORDS_LOG2 (LINE_WORDS_LOG2)
   ) u_fsm (
      .clk           (clk),
      .rst_n         (rst_n),
      .req_valid     (req_valid),
      .hit           (hit),
      .req_addr      (req_addr),
      .mem_req_ready (mem_req_ready),
      .mem_rsp_valid (mem_rsp_valid),
      .state         (state),
      .miss_addr     (miss_addr),
      .mem_req_valid (mem_req_valid),
      .line_inval    (line_inval),
      .word_we       (word_we),
      .word_sel      (word_sel),
      .line_done     (line_done),
      .start_miss    (start_miss)
   );

   // Valid bit drops as soon as the miss starts so a partially written line
   // can never hit; it is set again only with the last beat.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
      end else begin
         if (line_inval) valid_q[req_idx]  <= 1'b0;
         if (line_done)  valid_q[miss_idx] <= 1'b1;
      end
   end

   // Tag and data contents are qualified by valid_q and need no reset.
   always_ff @(posedge clk) begin
      if (word_we)   data_q[miss_idx][word_sel] <= mem_rsp_data;
      if (line_done) tag_q[miss_idx]            <= miss_tag;
   end

`ifdef ICACHE_PERF_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_hits   <= '0;
         perf_misses <= '0;
      end else begin
         if (out_valid  && (perf_hits   != 32'hFFFF_FFFF)) perf_hits   <= perf_hits + 32'd1;
         if (start_miss && (perf_misses != 32'hFFFF_FFFF)) perf_misses <= perf_misses + 32'd1;
      end
   end
`endif

endmodule
